// File: rtl/spi_apb_pkg.sv
// Shared types and the SPI controller register map for the APB sequencer master.
package spi_apb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } apb_state_e;

    // Byte offsets of the SPI controller APB register slave.
    localparam int unsigned STATUS = 32'h00;
    localparam int unsigned CLKDIV = 32'h04;
    localparam int unsigned SPICMD = 32'h08;
    localparam int unsigned SPIADR = 32'h0C;
    localparam int unsigned SPILEN = 32'h10;
    localparam int unsigned SPIDUM = 32'h14;
    localparam int unsigned TXFIFO = 32'h18;
    localparam int unsigned RXFIFO = 32'h20;
    localparam int unsigned INTCFG = 32'h24;
    localparam int unsigned INTSTA = 32'h28;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } apb_rsp_t;

endpackage

// File: rtl/spi_apb_master.sv
// Single-transfer APB3 initiator driven by a valid/ready request and returning a
// valid/ready response; handles wait states, PSLVERR and a bounded-wait timeout.
module spi_apb_master
    import spi_apb_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr,
    input  logic                      req_write,
    input  logic [31:0]               req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CntW      = TimeoutEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    apb_state_e                state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      rsp_valid_q, rsp_valid_d;
    apb_rsp_t                  rsp_q, rsp_d;

    // Byte lanes are implied by the word-aligned APB address.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    // APB strobes and rsp_valid are computed one cycle ahead so they leave a flop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_d       = rsp_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    paddr_d  = {req_addr[APB_ADDR_WIDTH-1:2], 2'b00};
                    pwrite_d = req_write;
                    pwdata_d = req_write ? req_wdata : 32'h0;
                    psel_d   = 1'b1;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                cnt_d     = '0;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                state_d   = StAccess;
            end
            StAccess: begin
                if (PREADY) begin
                    rsp_d.rdata   = (!pwrite_q && !PSLVERR) ? PRDATA : 32'h0;
                    rsp_d.err     = PSLVERR;
                    rsp_d.timeout = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = StResp;
                end else if (TimeoutEn && (cnt_q == CntLast)) begin
                    rsp_d.rdata   = 32'h0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = StResp;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready   = (state_q == StIdle) && !HRESET;
    assign busy        = (state_q != StIdle);
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PWRITE      = pwrite_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_spi_apb_master.sv
// Scoreboard bench for spi_apb_master with a configurable APB responder model.
module tb_spi_apb_master;
    import spi_apb_pkg::*;

    localparam int unsigned AW = 12;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          req_write = 1'b0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          busy;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    // Responder: raises PREADY on ACCESS cycle index cfg_waits unless stuck.
    int          cfg_waits = 0;
    logic        cfg_stuck = 1'b0;
    logic        cfg_err = 1'b0;
    logic [31:0] cfg_rdata = '0;
    int          acc_cnt = 0;

    assign PREADY  = PSEL && PENABLE && !cfg_stuck && (acc_cnt == cfg_waits);
    assign PSLVERR = PREADY && cfg_err;
    assign PRDATA  = cfg_rdata;

    always @(posedge HCLK) begin
        acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
    end

    spi_apb_master #(
        .APB_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PWRITE     (PWRITE),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Response monitor: every handshake must match the oldest expectation.
    always @(negedge HCLK) begin
        if (!HRESET && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check_value("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_value("rsp_rdata", rsp_rdata, mon_e.rdata);
                check_value("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
                check_value("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, mon_e.to});
            end
        end
    end

    task automatic run_xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata,
                            input int waits, input logic stuck, input logic slverr,
                            input logic [31:0] rdata, input int exp_acc,
                            input logic [31:0] exp_rdata, input logic exp_err,
                            input logic exp_to);
        int   n_acc;
        exp_t e;
        cfg_waits = waits;
        cfg_stuck = stuck;
        cfg_err   = slverr;
        cfg_rdata = rdata;
        check_value("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_addr  = addr;
        req_write = wr;
        req_wdata = wdata;
        req_valid = 1'b1;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.to    = exp_to;
        exp_q.push_back(e);
        tick();
        req_valid = 1'b0;
        check_value("setup_psel", {31'd0, PSEL}, 32'd1);
        check_value("setup_penable", {31'd0, PENABLE}, 32'd0);
        check_value("setup_req_ready", {31'd0, req_ready}, 32'd0);
        n_acc = 0;
        tick();
        while (PENABLE && n_acc < 64) begin
            check_value("acc_paddr", {20'd0, PADDR}, {20'd0, addr[AW-1:2], 2'b00});
            check_value("acc_pwrite", {31'd0, PWRITE}, {31'd0, wr});
            check_value("acc_pwdata", PWDATA, wr ? wdata : 32'h0);
            n_acc++;
            tick();
        end
        check_value("acc_cycles", n_acc, exp_acc);
        check_value("resp_psel", {31'd0, PSEL}, 32'd0);
        check_value("resp_valid", {31'd0, rsp_valid}, 32'd1);
        tick();
        check_value("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_value("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_rsp_valid(input string tag);
        int guard;
        guard = 0;
        while (!rsp_valid && guard < 40) begin
            tick();
            guard++;
        end
        check_value(tag, {31'd0, rsp_valid}, 32'd1);
    endtask

    initial begin
        exp_t e;
        // Request held during reset must be ignored.
        req_valid = 1'b1;
        repeat (3) tick();
        check_value("rst_psel", {31'd0, PSEL}, 32'd0);
        check_value("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check_value("rst_busy", {31'd0, busy}, 32'd0);
        check_value("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_value("rst_paddr", {20'd0, PADDR}, 32'd0);
        req_valid = 1'b0;
        HRESET = 1'b0;
        tick();
        check_value("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        run_xfer(AW'(CLKDIV), 1'b1, 32'h0000_0005, 0, 1'b0, 1'b0, 32'h0, 1, 32'h0, 1'b0, 1'b0);
        run_xfer(AW'(INTSTA), 1'b0, 32'h1111_2222, 3, 1'b0, 1'b0, 32'hDEAD_BEEF, 4,
                 32'hDEAD_BEEF, 1'b0, 1'b0);
        run_xfer(AW'(RXFIFO), 1'b0, 32'h0, 1, 1'b0, 1'b1, 32'h1234_5678, 2, 32'h0, 1'b1, 1'b0);
        run_xfer(AW'(SPICMD), 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h5555_AAAA, 8, 32'h0, 1'b1, 1'b1);
        // Ready on the last allowed cycle must win over the timeout.
        run_xfer(AW'(SPILEN), 1'b0, 32'h0, 7, 1'b0, 1'b0, 32'h0BAD_F00D, 8,
                 32'h0BAD_F00D, 1'b0, 1'b0);
        run_xfer(12'h02B, 1'b1, 32'hCAFE_0001, 0, 1'b1, 1'b0, 32'h0, 8, 32'h0, 1'b1, 1'b1);

        // Response backpressure with a second request waiting.
        cfg_waits = 0; cfg_stuck = 1'b0; cfg_err = 1'b0; cfg_rdata = 32'hA5A5_0001;
        rsp_ready = 1'b0;
        req_addr = AW'(SPIADR); req_write = 1'b0; req_wdata = 32'h0; req_valid = 1'b1;
        e.rdata = 32'hA5A5_0001; e.err = 1'b0; e.to = 1'b0;
        exp_q.push_back(e);
        tick();
        req_addr = AW'(SPIDUM); req_write = 1'b1; req_wdata = 32'h0000_0077;
        wait_rsp_valid("bp_first_rsp");
        cfg_rdata = 32'hFFFF_0000;
        for (int i = 0; i < 5; i++) begin
            check_value("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check_value("bp_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
            check_value("bp_req_ready", {31'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        e.rdata = 32'h0; e.err = 1'b0; e.to = 1'b0;
        exp_q.push_back(e);
        tick();
        check_value("bp_req_ready_after", {31'd0, req_ready}, 32'd1);
        check_value("bp_rsp_dropped", {31'd0, rsp_valid}, 32'd0);
        tick();
        req_valid = 1'b0;
        check_value("bp_second_psel", {31'd0, PSEL}, 32'd1);
        tick();
        check_value("bp_second_paddr", {20'd0, PADDR}, SPIDUM);
        check_value("bp_second_pwdata", PWDATA, 32'h0000_0077);
        wait_rsp_valid("bp_second_rsp");
        tick();

        // Reset during ACCESS drops the transfer without a response.
        cfg_stuck = 1'b1;
        req_addr = AW'(TXFIFO); req_write = 1'b1; req_wdata = 32'h0000_00C3; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check_value("mid_rst_access", {31'd0, PENABLE}, 32'd1);
        HRESET = 1'b1;
        tick();
        check_value("mid_rst_psel", {31'd0, PSEL}, 32'd0);
        check_value("mid_rst_penable", {31'd0, PENABLE}, 32'd0);
        check_value("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_value("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_value("mid_rst_pwdata", PWDATA, 32'd0);
        HRESET = 1'b0;
        tick();
        check_value("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        run_xfer(AW'(TXFIFO), 1'b1, 32'h0000_00C3, 2, 1'b0, 1'b0, 32'h0, 3, 32'h0, 1'b0, 1'b0);

        repeat (2) tick();
        check_value("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_apb_master.md
Name: spi_apb_master

Overview:
- APB3 initiator that turns a simple valid/ready request into a single APB transfer and returns a valid/ready response.
- Used by on-chip sequencers (boot loader, test controller) to program the SPI controller's APB register slave without a CPU.
- Handles responder wait states (PREADY), error responses (PSLVERR) and a bounded-wait timeout.

Parameters:
- APB_ADDR_WIDTH, 12, width of PADDR and req_addr.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before abort. 0 disables the timeout.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_addr  in  APB_ADDR_WIDTH  byte address.
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data.
- rsp_err  out  1  PSLVERR or timeout.
- rsp_timeout  out  1  transfer aborted by the timeout.
- busy  out  1  FSM not in IDLE.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Clock and reset: single clock domain (HCLK). HRESET is synchronous, active-high.
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready = 1, busy = 0.
  - On req_valid: capture PADDR = {req_addr[W-1:2], 2'b00}, PWRITE = req_write, PWDATA = req_wdata (0 for reads); go to SETUP.
- SETUP (exactly one cycle):
  - PSEL = 1, PENABLE = 0; go to ACCESS.
  - Timeout counter cleared.
- ACCESS:
  - PSEL = 1, PENABLE = 1; PADDR, PWRITE and PWDATA held stable.
  - PREADY = 1: capture rsp_rdata = (read && !PSLVERR) ? PRDATA : 0, rsp_err = PSLVERR, rsp_timeout = 0; go to RESP.
  - PREADY = 0: increment counter.
  - Timeout: when TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES - 1 with PREADY still 0, abort. Set rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0; go to RESP.
  - PREADY beats timeout if both occur on the same cycle.
  - Counter width: $clog2(TIMEOUT_CYCLES + 1), saturating.
- RESP:
  - PSEL = 0, PENABLE = 0; rsp_valid = 1.
  - rsp_rdata, rsp_err and rsp_timeout held stable until rsp_ready.
  - On rsp_ready: go to IDLE; rsp_valid drops the next cycle.
- Latency:
  - Zero-wait responder: accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid at 3.
  - Each wait state adds one cycle.
  - Peak throughput: one transfer per 4 cycles.
- PSEL/PENABLE are registered outputs and are glitch-free.
- req_ready is 0 outside IDLE; requests are never dropped, only stalled.
- PADDR, PWRITE and PWDATA keep their last values in IDLE/RESP (no toggling when idle).
- HRESET mid-transfer: the next edge forces IDLE and all outputs to 0, including PSEL. The in-flight transfer is lost with no response; the requester must re-issue.
- req_valid asserted during reset: ignored; sampled again in IDLE after reset.

Decomposition:
- Package spi_apb_pkg:
  - state enum typedef (IDLE/SETUP/ACCESS/RESP).
  - Byte-offset localparams of the SPI register map: STATUS 0x00, CLKDIV 0x04, SPICMD 0x08, SPIADR 0x0C, SPILEN 0x10, SPIDUM 0x14, TXFIFO 0x18, RXFIFO 0x20, INTCFG 0x24, INTSTA 0x28.
  - Response record typedef.
- No sub-module: single module, timeout counter inline.

Test Plan:
- Write 0x0000_0005 to 0x004, PREADY tied 1 → PSEL rises at cycle 1, PENABLE at cycle 2 with PADDR = 0x004, PWRITE = 1, PWDATA = 5. rsp_valid at cycle 3 with rsp_err = 0.
- Read 0x028 with PRDATA = 0xDEAD_BEEF, PREADY low for 3 ACCESS cycles → PENABLE high for 4 cycles, address stable. rsp_rdata = 0xDEAD_BEEF at cycle 6.
- Read 0x020 with PSLVERR = 1 on the ready cycle → rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0.
- TIMEOUT_CYCLES = 8, PREADY stuck 0 → PENABLE high exactly 8 cycles, then PSEL = 0. rsp_err = 1, rsp_timeout = 1.
- Hold rsp_ready = 0 for 5 cycles with req_valid held high → rsp stable, req_ready = 0 throughout. The second request is accepted in the cycle after the rsp handshake.
- Assert HRESET during ACCESS of a write to 0x018 → next cycle PSEL = PENABLE = rsp_valid = busy = 0, FSM in IDLE. No response is issued; a fresh request then completes normally.
